// File: rtl/gpu_line_memory.sv
// ----------------------------------------------------------------------------
// gpu_line_memory
//
// Line-organized data cache between the instruction decoder and the FMA array.
// Memory opcodes in the instruction stream do three things:
//   - build a line one word at a time from immediates (SMA / LOADI / SENDL),
//   - store a line taken from the FMA write buffer (LOADB),
//   - read a line out to the FMA read buffer as packed (a,b,c) operands (WRITEB).
// Every other opcode is ignored here; the rest of the GPU handles it.
//
// Instruction fields: op = [31:28], reg_a = [27:24], imm = [23:8], [7:0] unused.
//
// Ports
//   clk_in          in   1                  clock, rising edge
//   rst_in          in   1                  asynchronous, active-high reset
//   buffer_read_in  in   LINE_WIDTH         line from the FMA write buffer (LOADB data)
//   instr_in        in   INSTRUCTION_WIDTH  instruction word
//   instr_valid_in  in   1                  instr_in is valid this cycle
//   abc_out         out  LINE_WIDTH         line read out to the FMA read buffer
//   abc_valid_out   out  1                  one-cycle pulse: abc_out holds fresh read data
//
// Read latency: a WRITEB accepted at edge N presents its line on abc_out, with
// abc_valid_out high, during the cycle after edge N+2. abc_out holds its value
// between reads.
//
// Writes (SENDL/LOADB) are registered and commit one cycle after acceptance.
// The array is read-first, so a WRITEB accepted the cycle right after a write
// to the same address sees the old line, unless the build defines
// MEMORY_RAW_FORWARD_EN, in which case the pending write is forwarded.
//
// WORD_WIDTH is limited to 16 (the immediate width) and the line to at most
// 16 words (the reg_a field range).
// ----------------------------------------------------------------------------
module gpu_line_memory #(
    parameter int FMA_COUNT         = 2,
    parameter int WORD_WIDTH        = 16,
    parameter int LINE_WIDTH        = 96,
    parameter int ADDR_LENGTH       = 9,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [LINE_WIDTH-1:0]        buffer_read_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid_in,
    output logic [LINE_WIDTH-1:0]        abc_out,
    output logic                         abc_valid_out
);

    localparam int WORDS = 3 * FMA_COUNT;
    localparam int DEPTH = 1 << ADDR_LENGTH;

    typedef enum logic [3:0] {
        OP_SMA    = 4'b0110,
        OP_LOADI  = 4'b0111,
        OP_LOADB  = 4'b1010,
        OP_WRITEB = 4'b1100,
        OP_SENDL  = 4'b1110
    } opcode_e;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  op;
    logic [3:0]  reg_a;
    logic [15:0] imm;
    logic        unused_bits;

    assign op          = instr_in[31:28];
    assign reg_a       = instr_in[27:24];
    assign imm         = instr_in[23:8];
    assign unused_bits = ^instr_in[7:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic do_sma;
    logic do_loadi;
    logic do_sendl;
    logic do_loadb;
    logic do_writeb;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        do_sma    = 1'b0;
        do_loadi  = 1'b0;
        do_sendl  = 1'b0;
        do_loadb  = 1'b0;
        do_writeb = 1'b0;
        if (instr_valid_in) begin
            case (op)
                OP_SMA:    do_sma    = 1'b1;
                OP_LOADI:  do_loadi  = 1'b1;
                OP_SENDL:  do_sendl  = 1'b1;
                OP_LOADB:  do_loadb  = 1'b1;
                OP_WRITEB: do_writeb = 1'b1;
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state: address register, staging line, write/read pipelines
    // ------------------------------------------------------------------
    logic [ADDR_LENGTH-1:0] addr_reg;
    logic [LINE_WIDTH-1:0]  staging;
    logic                   wr_en_q;
    logic [ADDR_LENGTH-1:0] wr_addr_q;
    logic [LINE_WIDTH-1:0]  wr_data_q;
    logic                   rd_v0;      // array read registered this edge
    logic                   rd_v1;      // data in the second read stage
    logic [LINE_WIDTH-1:0]  mem_dout;   // array output register
    logic [LINE_WIDTH-1:0]  dout_q;     // second read stage

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_reg      <= '0;
            staging       <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_v0         <= 1'b0;
            rd_v1         <= 1'b0;
            abc_valid_out <= 1'b0;
            abc_out       <= '0;
        end else begin
            if (do_sma) begin
                addr_reg <= imm[ADDR_LENGTH-1:0];
            end

            // reg_a values past the last word match no slot and are dropped.
            for (int w = 0; w < WORDS; w++) begin
                if (do_loadi && (reg_a == 4'(w))) begin
                    staging[w*WORD_WIDTH +: WORD_WIDTH] <= imm[WORD_WIDTH-1:0];
                end
            end

            // The address is captured at acceptance so a following SMA
            // cannot redirect a write that is still pending.
            wr_en_q <= do_sendl | do_loadb;
            if (do_sendl || do_loadb) begin
                wr_addr_q <= addr_reg;
                wr_data_q <= do_loadb ? buffer_read_in : staging;
            end

            rd_v0         <= do_writeb;
            rd_v1         <= rd_v0;
            abc_valid_out <= rd_v1;
            if (rd_v1) begin
                abc_out <= dout_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line array: one write port, one registered read port
    // ------------------------------------------------------------------
    logic [LINE_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its datapath registers have no reset, so they map
    // onto block RAM; the reset-cleared valid flags keep stale data from
    // ever being presented.
    always_ff @(posedge clk_in) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    // Read and write sample at the same edge, so the read returns the line
    // as it was before a write committing on that edge (read-first).
    always_ff @(posedge clk_in) begin
        if (do_writeb) begin
            mem_dout <= mem[addr_reg];
        end
    end

`ifdef MEMORY_RAW_FORWARD_EN
    // A write still waiting to commit to the read address is captured beside
    // the array read and substituted in the second stage, keeping the array
    // read path a plain registered RAM read.
    logic                  fwd_sel_q;
    logic [LINE_WIDTH-1:0] fwd_line_q;

    always_ff @(posedge clk_in) begin
        if (do_writeb) begin
            fwd_sel_q  <= wr_en_q && (wr_addr_q == addr_reg);
            fwd_line_q <= wr_data_q;
        end
        if (rd_v0) begin
            dout_q <= fwd_sel_q ? fwd_line_q : mem_dout;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (rd_v0) begin
            dout_q <= mem_dout;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_line_memory.sv
// ----------------------------------------------------------------------------
// tb_gpu_line_memory
//
// Directed bench for gpu_line_memory. A table of {instruction, inputs,
// expected outputs} records is applied one per clock; the reset sequences are
// written out by hand. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point. Expected forwarding behaviour follows
// MEMORY_RAW_FORWARD_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpu_line_memory;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_END    = 4'b0001;
    localparam logic [3:0] OP_SMA    = 4'b0110;
    localparam logic [3:0] OP_LOADI  = 4'b0111;
    localparam logic [3:0] OP_LOADB  = 4'b1010;
    localparam logic [3:0] OP_WRITEB = 4'b1100;
    localparam logic [3:0] OP_SENDL  = 4'b1110;

    localparam logic [95:0] L1 = 96'h8883_8884_8885_8886_8887_8888;
    localparam logic [95:0] A0 = 96'hA000_A000_A000_A000_A000_A000;
    localparam logic [95:0] AA = 96'hAA00_A000_A000_A000_A000_A000;
    localparam logic [95:0] C5 = 96'h5555_5555_5555_5555_5555_5555;
    localparam logic [95:0] F1 = 96'h1111_1111_1111_1111_1111_1111;
    localparam logic [95:0] F2 = 96'h2222_2222_2222_2222_2222_2222;
    localparam logic [95:0] Z  = 96'h0;

`ifdef MEMORY_RAW_FORWARD_EN
    localparam logic [95:0] RAW_LOADB_EXP = F2;
    localparam logic [95:0] RAW_SENDL_EXP = L1;
`else
    localparam logic [95:0] RAW_LOADB_EXP = F1;
    localparam logic [95:0] RAW_SENDL_EXP = F2;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [95:0] buffer_read_in;
    logic [31:0] instr_in;
    logic        instr_valid_in;
    logic [95:0] abc_out;
    logic        abc_valid_out;

    gpu_line_memory dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .buffer_read_in (buffer_read_in),
        .instr_in       (instr_in),
        .instr_valid_in (instr_valid_in),
        .abc_out        (abc_out),
        .abc_valid_out  (abc_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] actual,
                         input logic [95:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ra,
                                       input logic [15:0] imm, input logic [7:0] lo);
        return {op, ra, imm, lo};
    endfunction

    // Drive one instruction and advance past the next rising edge.
    task automatic step(input logic [31:0] ins, input logic vld, input logic [95:0] bus);
        instr_in       = ins;
        instr_valid_in = vld;
        buffer_read_in = bus;
        @(posedge clk_in);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        vld;
        logic [95:0] bus;
        logic        exp_valid;
        logic        chk_data;
        logic [95:0] exp_abc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [31:0] ins, input logic vld,
                       input logic [95:0] bus, input logic ev, input logic cd,
                       input logic [95:0] ea);
        vec_t v;
        v.name = name; v.instr = ins; v.vld = vld; v.bus = bus;
        v.exp_valid = ev; v.chk_data = cd; v.exp_abc = ea;
        vecs.push_back(v);
    endtask

    task automatic op(input string name, input logic [31:0] ins);
        add(name, ins, 1'b1, Z, 1'b0, 1'b0, Z);
    endtask

    task automatic expect_read(input string name, input logic [95:0] ea);
        add(name, mk(OP_NOP, 4'd0, 16'h0, 8'h0), 1'b1, Z, 1'b1, 1'b1, ea);
    endtask

    task automatic expect_idle(input string name);
        add(name, mk(OP_NOP, 4'd0, 16'h0, 8'h0), 1'b1, Z, 1'b0, 1'b0, Z);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            step(vecs[i].instr, vecs[i].vld, vecs[i].bus);
            check({vecs[i].name, ".valid"}, {95'd0, abc_valid_out}, {95'd0, vecs[i].exp_valid});
            if (vecs[i].chk_data) begin
                check({vecs[i].name, ".abc"}, abc_out, vecs[i].exp_abc);
            end
        end
    endtask

    logic [31:0] NOP;
    logic [31:0] WB;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        NOP = mk(OP_NOP, 4'd0, 16'h0, 8'h0);
        WB  = mk(OP_WRITEB, 4'd0, 16'h0, 8'h0);

        // Build/store/read at 0x178.
        add("sma178", mk(OP_SMA, 4'd0, 16'h0178, 8'h5A), 1'b1, Z, 1'b0, 1'b1, Z);
        op("li0", mk(OP_LOADI, 4'd0, 16'h8888, 8'h00));
        op("li1", mk(OP_LOADI, 4'd1, 16'h8887, 8'hFF));
        op("li2", mk(OP_LOADI, 4'd2, 16'h8886, 8'h00));
        op("li3", mk(OP_LOADI, 4'd3, 16'h8885, 8'h00));
        op("li4", mk(OP_LOADI, 4'd4, 16'h8884, 8'h00));
        op("li5", mk(OP_LOADI, 4'd5, 16'h8883, 8'h00));
        op("sendl178", mk(OP_SENDL, 4'd3, 16'h01FC, 8'h00));
        op("nop", NOP);
        op("sma178b", mk(OP_SMA, 4'd0, 16'h0178, 8'h00));
        op("wb178", WB);
        expect_idle("wb178_lat1");
        expect_read("wb178_data", L1);
        add("wb178_hold", NOP, 1'b1, Z, 1'b0, 1'b1, L1);

        // Second address: SENDL then LOADB at 0x1FC, read both back.
        op("sma1fc", mk(OP_SMA, 4'd0, 16'h01FC, 8'h00));
        op("sendl1fc", mk(OP_SENDL, 4'd0, 16'h0000, 8'h00));
        add("loadb1fc", mk(OP_LOADB, 4'd0, 16'h0178, 8'h00), 1'b1, AA, 1'b0, 1'b0, Z);
        op("nop", NOP);
        op("wb1fc", WB);
        expect_idle("wb1fc_lat1");
        expect_read("wb1fc_data", AA);
        op("sma178c", mk(OP_SMA, 4'd0, 16'h0178, 8'h00));
        op("wb178_indep", WB);
        expect_idle("wb178_indep_lat1");
        expect_read("wb178_indep_data", L1);

        // LOADB round trip at 0x178.
        add("loadb178", mk(OP_LOADB, 4'd0, 16'h01FC, 8'h00), 1'b1, A0, 1'b0, 1'b0, Z);
        op("nop", NOP);
        op("wb178_lb", WB);
        expect_idle("wb178_lb_lat1");
        expect_read("wb178_lb_data", A0);

        // Valid gating and ignored opcodes.
        op("sma1fc_b", mk(OP_SMA, 4'd0, 16'h01FC, 8'h00));
        add("gated_sma", mk(OP_SMA, 4'd0, 16'h0005, 8'h00), 1'b0, Z, 1'b0, 1'b0, Z);
        add("gated_wb", WB, 1'b0, C5, 1'b0, 1'b0, Z);
        add("gated_sendl", mk(OP_SENDL, 4'd0, 16'h0, 8'h0), 1'b0, C5, 1'b0, 1'b0, Z);
        add("gated_loadb", mk(OP_LOADB, 4'd0, 16'h0, 8'h0), 1'b0, C5, 1'b0, 1'b0, Z);
        add("op0000", mk(OP_NOP, 4'd2, 16'hFFFF, 8'h0), 1'b1, C5, 1'b0, 1'b0, Z);
        add("op0001", mk(OP_END, 4'd1, 16'h0005, 8'h0), 1'b1, C5, 1'b0, 1'b0, Z);
        add("op1111", mk(4'b1111, 4'd0, 16'h0005, 8'h0), 1'b1, C5, 1'b0, 1'b1, A0);
        expect_idle("gated_idle");
        op("wb1fc_gated", WB);
        expect_idle("wb1fc_gated_lat1");
        expect_read("wb1fc_gated_data", AA);

        // Upper SMA bits ignored; out-of-range LOADI slots dropped.
        op("sma_fe05", mk(OP_SMA, 4'd0, 16'hFE05, 8'h00));
        op("li6", mk(OP_LOADI, 4'd6, 16'hFFFF, 8'h00));
        op("li15", mk(OP_LOADI, 4'd15, 16'hFFFF, 8'h00));
        op("sendl005", NOP | mk(OP_SENDL, 4'd0, 16'h0, 8'h0));
        op("nop", NOP);
        op("sma005", mk(OP_SMA, 4'd0, 16'h0005, 8'h00));
        op("wb005", WB);
        expect_idle("wb005_lat1");
        expect_read("wb005_data", L1);

        // Back-to-back reads, different then same address.
        op("sma178d", mk(OP_SMA, 4'd0, 16'h0178, 8'h00));
        op("b2b_wb178", WB);
        op("b2b_sma1fc", mk(OP_SMA, 4'd0, 16'h01FC, 8'h00));
        add("b2b_wb1fc", WB, 1'b1, Z, 1'b1, 1'b1, A0);
        add("b2b_gap", NOP, 1'b1, Z, 1'b0, 1'b1, A0);
        expect_read("b2b_1fc", AA);
        op("b2b_wb_a", WB);
        op("b2b_wb_b", WB);
        expect_read("b2b_pulse_a", AA);
        expect_read("b2b_pulse_b", AA);
        expect_idle("b2b_end");

        // Read immediately after a write to the same address.
        op("sma0aa", mk(OP_SMA, 4'd0, 16'h00AA, 8'h00));
        add("loadb_f1", mk(OP_LOADB, 4'd0, 16'h0, 8'h0), 1'b1, F1, 1'b0, 1'b0, Z);
        op("nop", NOP);
        op("nop", NOP);
        add("loadb_f2", mk(OP_LOADB, 4'd0, 16'h0, 8'h0), 1'b1, F2, 1'b0, 1'b0, Z);
        op("raw_wb_loadb", WB);
        expect_idle("raw_loadb_lat1");
        expect_read("raw_loadb_data", RAW_LOADB_EXP);
        expect_idle("raw_loadb_end");
        op("wb0aa_late", WB);
        expect_idle("wb0aa_late_lat1");
        expect_read("wb0aa_late_data", F2);
        op("sendl0aa", mk(OP_SENDL, 4'd0, 16'h0, 8'h0));
        op("raw_wb_sendl", WB);
        expect_idle("raw_sendl_lat1");
        expect_read("raw_sendl_data", RAW_SENDL_EXP);

        // Preload address 0 for the post-reset checks.
        op("sma000", mk(OP_SMA, 4'd0, 16'h0000, 8'h00));
        add("loadb000", mk(OP_LOADB, 4'd0, 16'h0, 8'h0), 1'b1, C5, 1'b0, 1'b0, Z);
        op("nop", NOP);
        op("nop", NOP);

        // Power-on reset.
        rst_in = 1'b1;
        instr_in = NOP;
        instr_valid_in = 1'b0;
        buffer_read_in = '0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        check("reset.valid", {95'd0, abc_valid_out}, 96'd0);
        check("reset.abc", abc_out, Z);
        rst_in = 1'b0;

        run_table();

        // Reset one cycle after a WRITEB: no pulse, output cleared.
        step(mk(OP_SMA, 4'd0, 16'h0178, 8'h00), 1'b1, Z);
        step(WB, 1'b1, Z);
        step(NOP, 1'b1, Z);
        rst_in = 1'b1;
        #1;
        check("midrst.async_abc", abc_out, Z);
        check("midrst.async_valid", {95'd0, abc_valid_out}, 96'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_in); #1;
            check("midrst.held_valid", {95'd0, abc_valid_out}, 96'd0);
        end
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(NOP, 1'b1, Z);
            check("midrst.no_pulse", {95'd0, abc_valid_out}, 96'd0);
            check("midrst.abc_zero", abc_out, Z);
        end

        // addr_reg came back as 0: this reads the preloaded 0x000 line.
        step(WB, 1'b1, Z);
        step(NOP, 1'b1, Z);
        step(NOP, 1'b1, Z);
        check("postrst_addr0.valid", {95'd0, abc_valid_out}, 96'd1);
        check("postrst_addr0.abc", abc_out, C5);

        // staging came back as 0.
        step(mk(OP_SENDL, 4'd0, 16'h0, 8'h0), 1'b1, Z);
        step(NOP, 1'b1, Z);
        step(WB, 1'b1, Z);
        step(NOP, 1'b1, Z);
        step(NOP, 1'b1, Z);
        check("postrst_staging.valid", {95'd0, abc_valid_out}, 96'd1);
        check("postrst_staging.abc", abc_out, Z);

        // Array contents survive reset.
        step(mk(OP_SMA, 4'd0, 16'h0178, 8'h00), 1'b1, Z);
        step(WB, 1'b1, Z);
        step(NOP, 1'b1, Z);
        step(NOP, 1'b1, Z);
        check("postrst_178.valid", {95'd0, abc_valid_out}, 96'd1);
        check("postrst_178.abc", abc_out, A0);
        step(mk(OP_SMA, 4'd0, 16'h01FC, 8'h00), 1'b1, Z);
        step(WB, 1'b1, Z);
        step(NOP, 1'b1, Z);
        step(NOP, 1'b1, Z);
        check("postrst_1fc.valid", {95'd0, abc_valid_out}, 96'd1);
        check("postrst_1fc.abc", abc_out, AA);
        step(NOP, 1'b1, Z);
        check("postrst_1fc.pulse_end", {95'd0, abc_valid_out}, 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
